decode_pipe: RTL and testbench



---
 rtl/decode_pipe_if.sv | 27 ++
 rtl/decode_pipe.sv | 167 ++++++++++++++++
 tb/tb_decode_pipe.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch-side and issue-side bundle for decode_pipe, plus the flush strobe.
// Handshake: a word moves on every rising edge where valid and ready are both 1; valid never waits on ready.
interface decode_pipe_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_inst;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_inst;
   logic [XLEN-1:0] out_pc;
   logic [23:0]     out_ctrl;
   logic            out_illegal;

   modport slave (
      input  flush, in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_inst, out_pc, out_ctrl, out_illegal
   );

   modport master (
      output flush, in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_inst, out_pc, out_ctrl, out_illegal
   );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: RV32I decode stage with a registered output and one skid entry (EMPTY/MAIN/FULL).
// Optional macro DECODE_PIPE_MEXT_EN makes OP with funct7=0x01 (M extension) legal.
module decode_pipe #(
   parameter int XLEN      = 32,
   parameter int IMM_SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   decode_pipe_if.slave     bus,
   output logic [1:0]       dbg_state
);
   if (XLEN != 32) begin : g_xlen_chk
      $error("decode_pipe: XLEN must be 32");
   end
   if (IMM_SEL_W < 3) begin : g_imm_chk
      $error("decode_pipe: IMM_SEL_W must be at least 3");
   end

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam int         PW         = 2 * XLEN + 25;

   typedef enum logic [1:0] {S_EMPTY = 2'd0, S_MAIN = 2'd1, S_FULL = 2'd2} state_t;

   state_t                state, state_nxt;
   logic [PW-1:0]         main_q, skid_q, dec_word;
   logic                  accept, drain, load_main_in, load_main_skid, load_skid;

   logic [6:0]            opcode, funct7;
   logic [2:0]            funct3;
   logic [IMM_SEL_W-1:0]  imm_sel;
   logic [2:0]            alu_ctrl;
   logic                  wen, rmem, wmem, jmp, jcc, lui, jal, jalr, auipc, inst_r, mext;
   logic                  legal, dec_ill;
   logic [23:0]           dec_ctrl;

   assign opcode = bus.in_inst[6:0];
   assign funct3 = bus.in_inst[14:12];
   assign funct7 = bus.in_inst[31:25];

   always_comb begin
      imm_sel  = '0;
      alu_ctrl = funct3;
      wen      = 1'b0;
      rmem     = 1'b0;
      wmem     = 1'b0;
      jmp      = 1'b0;
      jcc      = 1'b0;
      lui      = 1'b0;
      jal      = 1'b0;
      jalr     = 1'b0;
      auipc    = 1'b0;
      inst_r   = 1'b0;
      mext     = 1'b0;
      legal    = 1'b1;
      case (opcode)
         OPC_OP_IMM: begin
            imm_sel = (funct3 == 3'b011) ? IMM_SEL_W'(2) : IMM_SEL_W'(1);
            wen     = 1'b1;
         end
         OPC_OP: begin
            inst_r = 1'b1;
            wen    = 1'b1;
            if (funct7 == 7'h01) begin
`ifdef DECODE_PIPE_MEXT_EN
               mext  = 1'b1;
`else
               legal = 1'b0;
`endif
            end else if (funct7 != 7'h00 && funct7 != 7'h20) begin
               legal = 1'b0;
            end
         end
         OPC_LOAD:   begin imm_sel = IMM_SEL_W'(1); rmem = 1'b1; wen = 1'b1; end
         OPC_STORE:  begin imm_sel = IMM_SEL_W'(3); wmem = 1'b1; end
         OPC_BRANCH: begin imm_sel = IMM_SEL_W'(5); jcc = 1'b1; end
         OPC_JAL:    begin imm_sel = IMM_SEL_W'(6); alu_ctrl = 3'd0; jmp = 1'b1; jal = 1'b1; wen = 1'b1; end
         OPC_JALR:   begin imm_sel = IMM_SEL_W'(1); alu_ctrl = 3'd0; jmp = 1'b1; jalr = 1'b1; wen = 1'b1; end
         OPC_LUI:    begin imm_sel = IMM_SEL_W'(4); alu_ctrl = 3'd0; lui = 1'b1; wen = 1'b1; end
         OPC_AUIPC:  begin imm_sel = IMM_SEL_W'(4); alu_ctrl = 3'd0; auipc = 1'b1; wen = 1'b1; end
         default:    legal = 1'b0;
      endcase
      if (bus.in_inst[1:0] != 2'b11) legal = 1'b0;
      dec_ill = ~legal;
      // Illegal words still travel down the pipe but must have no side effects.
      if (dec_ill) begin
         wen  = 1'b0;
         rmem = 1'b0;
         wmem = 1'b0;
         jmp  = 1'b0;
         jcc  = 1'b0;
      end
      dec_ctrl = {2'b00, mext, (opcode == OPC_OP) & funct7[5], funct7[5], inst_r,
                  auipc, jalr, jal, lui, jcc, jmp, wen, wmem, rmem,
                  funct3[2], funct3[1:0], alu_ctrl, imm_sel[2:0]};
   end

   assign dec_word = {bus.in_inst, bus.in_pc, dec_ctrl, dec_ill};
   assign accept   = bus.in_valid & bus.in_ready;
   assign drain    = bus.out_valid & bus.out_ready;

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         S_EMPTY: if (accept) begin
            state_nxt    = S_MAIN;
            load_main_in = 1'b1;
         end
         S_MAIN: begin
            if (accept && drain) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               state_nxt = S_FULL;
               load_skid = 1'b1;
            end else if (drain) begin
               state_nxt = S_EMPTY;
            end
         end
         S_FULL: if (drain) begin
            state_nxt      = S_MAIN;
            load_main_skid = 1'b1;
         end
         default: state_nxt = S_EMPTY;
      endcase
      // Flush wins over everything, including an accept in the same cycle.
      if (bus.flush) begin
         state_nxt      = S_EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_EMPTY;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in)        main_q <= dec_word;
         else if (load_main_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= dec_word;
      end
   end

   assign bus.in_ready    = (state != S_FULL);
   assign bus.out_valid   = (state != S_EMPTY);
   assign bus.out_inst    = main_q[PW-1 -: XLEN];
   assign bus.out_pc      = main_q[XLEN+24 -: XLEN];
   assign bus.out_ctrl    = main_q[24:1];
   assign bus.out_illegal = main_q[0];
   assign dbg_state       = state;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed and random traffic through decode_pipe, checked against a hand-decoded table.
module tb_decode_pipe;
   localparam int NT = 14;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  dbg_state;
   logic        rnd_mode;
   logic [23:0] drv_ctrl;
   logic        drv_ill;
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_out = 0;
   int          n0;

   logic [31:0] t_inst [NT];
   logic [23:0] t_ctrl [NT];
   logic        t_ill  [NT];

   logic [88:0] exp_q[$];

   decode_pipe_if #(.XLEN(32)) bus ();

   decode_pipe #(.XLEN(32), .IMM_SEL_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_entry(input int i, input logic [31:0] inst, input logic [23:0] ctrl, input logic ill);
      t_inst[i] = inst;
      t_ctrl[i] = ctrl;
      t_ill[i]  = ill;
   endtask

   task automatic init_table();
      set_entry(0,  32'h00500093, 24'h000801, 1'b0); // addi
      set_entry(1,  32'h40208133, 24'h1C0800, 1'b0); // sub
      set_entry(2,  32'h0000A103, 24'h000A91, 1'b0); // lw
      set_entry(3,  32'h0000006F, 24'h009806, 1'b0); // jal
      set_entry(4,  32'h00000063, 24'h002005, 1'b0); // beq
      set_entry(5,  32'hFFFFFFFF, 24'h0801F8, 1'b1); // unknown opcode
`ifdef DECODE_PIPE_MEXT_EN
      set_entry(6,  32'h02208033, 24'h240800, 1'b0); // mul
`else
      set_entry(6,  32'h02208033, 24'h040000, 1'b1); // mul
`endif
      set_entry(7,  32'h00003013, 24'h0008DA, 1'b0); // sltiu
      set_entry(8,  32'h0020A023, 24'h000493, 1'b0); // sw
      set_entry(9,  32'h000010B7, 24'h004844, 1'b0); // lui
      set_entry(10, 32'h00000097, 24'h020804, 1'b0); // auipc
      set_entry(11, 32'h00008067, 24'h011801, 1'b0); // jalr
      set_entry(12, 32'h20000033, 24'h040000, 1'b1); // OP funct7=0x10
      set_entry(13, 32'h00500090, 24'h000000, 1'b1); // inst[1:0]=00
   endtask

   // Scoreboard: decisions are taken at the negedge, where inputs and outputs are both settled.
   always @(negedge clk) begin
      logic [88:0] e;
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            chk("out_has_pending", 96'(exp_q.size() != 0), 96'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("payload", 96'({bus.out_inst, bus.out_pc, bus.out_ctrl, bus.out_illegal}), 96'(e));
            end
         end
         if (bus.flush) exp_q.delete();
         else if (bus.in_valid && bus.in_ready)
            exp_q.push_back({bus.in_inst, bus.in_pc, drv_ctrl, drv_ill});
      end
   end

   always @(posedge clk) begin
      #1;
      if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));
   end

   task automatic load(input int idx);
      bus.in_valid = 1'b1;
      bus.in_inst  = t_inst[idx];
      bus.in_pc    = $urandom;
      drv_ctrl     = t_ctrl[idx];
      drv_ill      = t_ill[idx];
   endtask

   task automatic send(input int idx);
      int budget = 0;
      load(idx);
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         budget++;
         if (budget > 50) begin
            chk("send_timeout", 96'(budget), 96'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int budget = 0;
      while (exp_q.size() != 0 && budget <= 200) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (budget > 200) chk("drain_timeout", 96'(exp_q.size()), 96'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out_valid"}, 96'(bus.out_valid), 96'd0);
      chk({tag, "_in_ready"},  96'(bus.in_ready), 96'd1);
      chk({tag, "_ctrl"},      96'(bus.out_ctrl), 96'd0);
      chk({tag, "_illegal"},   96'(bus.out_illegal), 96'd0);
      chk({tag, "_inst"},      96'(bus.out_inst), 96'd0);
      chk({tag, "_pc"},        96'(bus.out_pc), 96'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      rnd_mode      = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_inst   = '0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b1;
      drv_ctrl      = '0;
      drv_ill       = 1'b0;
      init_table();
      #1;
      chk_all_zero("reset");
      chk("reset_state", 96'(dbg_state), 96'd0);

      // First accept on the first edge after release; addi appears one cycle later.
      load(0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("first_accept_valid", 96'(bus.out_valid), 96'd1);
      chk("addi_ctrl", 96'(bus.out_ctrl), 96'h000801);
      wait_drain();

      // Full table, back to back, no back-pressure.
      for (int i = 0; i < NT; i++) send(i);
      wait_drain();

      // Two accepts into a stalled output fill the skid; release drains in order.
      bus.out_ready = 1'b0;
      send(1);
      send(2);
      chk("full_in_ready", 96'(bus.in_ready), 96'd0);
      chk("full_state", 96'(dbg_state), 96'd2);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("stall_hold_inst", 96'(bus.out_inst), 96'(t_inst[1]));
      chk("stall_sub_bit", 96'(bus.out_ctrl[20]), 96'd1);
      n0 = n_out;
      bus.out_ready = 1'b1;
      wait_drain();
      chk("stall_release_count", 96'(n_out - n0), 96'd2);

      // Random gaps and random back-pressure.
      rnd_mode = 1'b1;
      repeat (60) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send($urandom_range(0, NT - 1));
      end
      rnd_mode = 1'b0;
      @(posedge clk);
      #2;
      bus.out_ready = 1'b1;
      wait_drain();

      // Flush while FULL, with a competing accept that must be dropped.
      bus.out_ready = 1'b0;
      send(0);
      send(3);
      chk("flush_pre_in_ready", 96'(bus.in_ready), 96'd0);
      load(4);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_out_valid", 96'(bus.out_valid), 96'd0);
      chk("flush_in_ready", 96'(bus.in_ready), 96'd1);
      chk("flush_state", 96'(dbg_state), 96'd0);
      bus.out_ready = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("flush_dropped", 96'(bus.out_valid), 96'd0);

      // Asynchronous reset in the middle of a stall, between clock edges.
      bus.out_ready = 1'b0;
      send(2);
      send(8);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      exp_q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      n0 = n_out;
      send(9);
      wait_drain();
      chk("post_reset_count", 96'(n_out - n0), 96'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
